// File: rtl/stereo_match_stream.sv
// Winner-take-all SAD/SSD block matcher: BLOCK*BLOCK + RD_LAT + 1 cycles per disparity per anchor.
// One result per anchor on a valid/ready stream; a stalled result freezes the BRAM addresses and all state.
module stereo_match_stream #(
  parameter int IMG_W    = 240,
  parameter int IMG_H    = 320,
  parameter int BLOCK    = 6,
  parameter int MAX_DISP = 32,
  parameter int PIX_W    = 8,
  parameter int RD_LAT   = 2,
  localparam int AW = $clog2(IMG_W * IMG_H),
  localparam int CW = 2 * PIX_W + $clog2(BLOCK * BLOCK) + 1,
  localparam int DW = $clog2(MAX_DISP + 1),
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic             clk_100mhz,
  input  logic             sys_rst,
  input  logic             start_in,
  input  logic             mode_in,
  output logic [AW-1:0]    left_addr_out,
  input  logic [PIX_W-1:0] left_din,
  output logic [AW-1:0]    right_addr_out,
  input  logic [PIX_W-1:0] right_din,
  output logic [DW-1:0]    disp_out,
  output logic [CW-1:0]    cost_out,
  output logic [XW-1:0]    x_out,
  output logic [YW-1:0]    y_out,
  output logic             disp_valid_out,
  input  logic             disp_ready_in,
  output logic             busy_out,
  output logic             frame_done_out
);

  localparam int BW = $clog2(BLOCK + 1);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - BLOCK);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - BLOCK);
  localparam logic [XW-1:0] D_MAX  = XW'(MAX_DISP);
  localparam logic [BW-1:0] B_LAST = BW'(BLOCK - 1);
  localparam logic [LW-1:0] L_LAST = LW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DRAIN, S_COMPARE, S_EMIT, S_DONE
  } state_t;

  state_t            r_state;
  logic              r_mode;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [DW-1:0]     r_d;
  logic [BW-1:0]     r_i;
  logic [BW-1:0]     r_j;
  logic [LW-1:0]     r_dcnt;
  logic              r_issue;
  logic [RD_LAT-1:0] r_vpipe;
  logic [CW-1:0]     r_acc;
  logic [CW-1:0]     r_best_cost;
  logic [DW-1:0]     r_best_d;
  logic [AW-1:0]     r_left_addr;
  logic [AW-1:0]     r_right_addr;
  logic [DW-1:0]     r_disp;
  logic [CW-1:0]     r_cost;
  logic [XW-1:0]     r_x_out;
  logic [YW-1:0]     r_y_out;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;

  logic [AW-1:0]      w_row;
  logic [AW-1:0]      w_lcol;
  logic [AW-1:0]      w_rcol;
  logic [AW-1:0]      w_left_addr;
  logic [AW-1:0]      w_right_addr;
  logic               w_smp_vld;
  logic [PIX_W-1:0]   w_diff;
  logic [2*PIX_W-1:0] w_sq;
  logic [CW-1:0]      w_term;
  logic [CW-1:0]      w_acc_nxt;
  logic [XW-1:0]      w_dlim;
  logic               w_more;
  logic               w_better;

  // The right column cannot underflow because d never exceeds the anchor x.
  assign w_row        = AW'(r_y) + AW'(r_j);
  assign w_lcol       = AW'(r_x) + AW'(r_i);
  assign w_rcol       = w_lcol - AW'(r_d);
  assign w_left_addr  = w_row * AW'(IMG_W) + w_lcol;
  assign w_right_addr = w_row * AW'(IMG_W) + w_rcol;

  assign w_smp_vld = r_vpipe[RD_LAT-1];
  assign w_diff    = (left_din >= right_din) ? (left_din - right_din) : (right_din - left_din);
  assign w_sq      = {{PIX_W{1'b0}}, w_diff} * {{PIX_W{1'b0}}, w_diff};
  assign w_term    = !w_smp_vld ? '0 : (r_mode ? CW'(w_sq) : CW'(w_diff));
  assign w_acc_nxt = r_acc + w_term;

  // COMPARE coincides with the last sample's return, so it judges the sum including that sample.
  assign w_dlim   = (r_x < D_MAX) ? r_x : D_MAX;
  assign w_more   = XW'(r_d) < w_dlim;
  assign w_better = (r_d == '0) || (w_acc_nxt < r_best_cost);

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_d          <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_dcnt       <= '0;
      r_issue      <= 1'b0;
      r_vpipe      <= '0;
      r_acc        <= '0;
      r_best_cost  <= '0;
      r_best_d     <= '0;
      r_left_addr  <= '0;
      r_right_addr <= '0;
      r_disp       <= '0;
      r_cost       <= '0;
      r_x_out      <= '0;
      r_y_out      <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_issue    <= 1'b0;
      r_vpipe[0] <= r_issue;
      for (int k = 1; k < RD_LAT; k++) r_vpipe[k] <= r_vpipe[k-1];
      if (w_smp_vld) r_acc <= w_acc_nxt;

      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start_in) begin
            r_mode  <= mode_in;
            r_x     <= '0;
            r_y     <= '0;
            r_d     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_FETCH: begin
          r_left_addr  <= w_left_addr;
          r_right_addr <= w_right_addr;
          r_issue      <= 1'b1;
          if (r_i == B_LAST) begin
            r_i <= '0;
            if (r_j == B_LAST) begin
              r_j     <= '0;
              r_dcnt  <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_j <= r_j + BW'(1);
            end
          end else begin
            r_i <= r_i + BW'(1);
          end
        end

        S_DRAIN: begin
          if (r_dcnt == L_LAST) r_state <= S_COMPARE;
          else                  r_dcnt  <= r_dcnt + LW'(1);
        end

        S_COMPARE: begin
          r_acc <= '0;
          if (w_better) begin
            r_best_cost <= w_acc_nxt;
            r_best_d    <= r_d;
          end
          if (w_more) begin
            r_d     <= r_d + DW'(1);
            r_state <= S_FETCH;
          end else begin
            r_disp  <= w_better ? r_d : r_best_d;
            r_cost  <= w_better ? w_acc_nxt : r_best_cost;
            r_x_out <= r_x;
            r_y_out <= r_y;
            r_valid <= 1'b1;
            r_state <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (disp_ready_in) begin
            r_valid <= 1'b0;
            r_d     <= '0;
            if (r_x == X_LAST) begin
              r_x <= '0;
              if (r_y == Y_LAST) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_y     <= r_y + YW'(1);
                r_state <= S_FETCH;
              end
            end else begin
              r_x     <= r_x + XW'(1);
              r_state <= S_FETCH;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign left_addr_out  = r_left_addr;
  assign right_addr_out = r_right_addr;
  assign disp_out       = r_disp;
  assign cost_out       = r_cost;
  assign x_out          = r_x_out;
  assign y_out          = r_y_out;
  assign disp_valid_out = r_valid;
  assign busy_out       = r_busy;
  assign frame_done_out = r_done;

endmodule

// File: tb/tb_stereo_match_stream.sv
// Bench for stereo_match_stream on an 8x4 frame: BRAM models with 2-cycle latency and a
// brute-force disparity search as reference for every streamed result.
module tb_stereo_match_stream;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int B  = 2;
  localparam int MD = 3;
  localparam int RL = 2;
  localparam int PW = 8;
  localparam int AW = $clog2(W * H);
  localparam int CW = 2 * PW + $clog2(B * B) + 1;
  localparam int DW = $clog2(MD + 1);
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int NX = W - B + 1;
  localparam int NY = H - B + 1;
  localparam int NA = NX * NY;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [AW-1:0] laddr;
  logic [AW-1:0] raddr;
  logic [PW-1:0] ldin;
  logic [PW-1:0] rdin;
  logic [DW-1:0] disp;
  logic [CW-1:0] cost;
  logic [XW-1:0] xo;
  logic [YW-1:0] yo;
  logic          vld;
  logic          rdy;
  logic          busy;
  logic          fdone;

  logic [PW-1:0] lmem [W*H];
  logic [PW-1:0] rmem [W*H];
  logic [PW-1:0] lp [RL];
  logic [PW-1:0] rp [RL];

  int   n_chk = 0;
  int   n_err = 0;
  int   n_res = 0;
  int   n_done = 0;
  logic cur_mode = 1'b0;

  stereo_match_stream #(
    .IMG_W(W), .IMG_H(H), .BLOCK(B), .MAX_DISP(MD), .PIX_W(PW), .RD_LAT(RL)
  ) dut (
    .clk_100mhz     (clk),
    .sys_rst        (rst),
    .start_in       (start),
    .mode_in        (mode),
    .left_addr_out  (laddr),
    .left_din       (ldin),
    .right_addr_out (raddr),
    .right_din      (rdin),
    .disp_out       (disp),
    .cost_out       (cost),
    .x_out          (xo),
    .y_out          (yo),
    .disp_valid_out (vld),
    .disp_ready_in  (rdy),
    .busy_out       (busy),
    .frame_done_out (fdone)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    lp[0] <= lmem[laddr];
    rp[0] <= rmem[raddr];
    for (int k = 1; k < RL; k++) begin
      lp[k] <= lp[k-1];
      rp[k] <= rp[k-1];
    end
  end
  assign ldin = lp[RL-1];
  assign rdin = rp[RL-1];

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Exhaustive search over all legal disparities; first minimum wins.
  task automatic ref_anchor(input int ax, input int ay, input logic md, output int bd, output int bc);
    int c, a, b, df, dl;
    bd = 0;
    bc = 0;
    dl = (ax < MD) ? ax : MD;
    for (int d = 0; d <= dl; d++) begin
      c = 0;
      for (int j = 0; j < B; j++) begin
        for (int i = 0; i < B; i++) begin
          a  = int'(lmem[(ay + j) * W + ax + i]);
          b  = int'(rmem[(ay + j) * W + ax - d + i]);
          df = (a > b) ? a - b : b - a;
          c  = c + (md ? df * df : df);
        end
      end
      if (d == 0 || c < bc) begin
        bd = d;
        bc = c;
      end
    end
  endtask

  always @(negedge clk) begin
    int ex, ey, ed, ec;
    if (!rst && vld && rdy) begin
      if (n_res >= NA) begin
        check("extra_result", n_res, NA - 1);
      end else begin
        ex = n_res % NX;
        ey = n_res / NX;
        ref_anchor(ex, ey, cur_mode, ed, ec);
        check("res_x", int'(xo), ex);
        check("res_y", int'(yo), ey);
        check("res_disp", int'(disp), ed);
        check("res_cost", int'(cost), ec);
      end
      n_res++;
    end
    if (!rst && fdone) n_done++;
  end

  task automatic fill(input int kind);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (kind)
          0: begin lmem[y*W+x] = PW'(16 * x); rmem[y*W+x] = PW'(16 * x);       end
          1: begin lmem[y*W+x] = PW'(16 * x); rmem[y*W+x] = PW'(16 * (x + 2)); end
          default: begin lmem[y*W+x] = PW'($urandom); rmem[y*W+x] = PW'($urandom); end
        endcase
      end
    end
  endtask

  task automatic start_frame(input logic md);
    n_res    = 0;
    n_done   = 0;
    cur_mode = md;
    @(posedge clk); #1;
    start = 1'b1;
    mode  = md;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input string tag, input bit rnd);
    int cyc = 0;
    while (n_done == 0 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (rnd) rdy = ($urandom_range(0, 2) != 0);
    end
    rdy = 1'b1;
    check({tag, "_timeout"}, int'(n_done > 0), 1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_results"}, n_res, NA);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  initial begin
    int ed, ec, cyc;
    logic md;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    rdy   = 1'b1;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(vld), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(fdone), 0);
    check("rst_laddr", int'(laddr), 0);
    check("rst_raddr", int'(raddr), 0);
    check("rst_disp", int'(disp), 0);
    check("rst_cost", int'(cost), 0);
    check("rst_x", int'(xo), 0);
    check("rst_y", int'(yo), 0);
    rst = 1'b0;

    // Identical frames, shifted frames, single-pixel perturbation under SSD.
    fill(0);
    start_frame(1'b0);
    wait_done("s1", 1'b0);
    fill(1);
    start_frame(1'b0);
    wait_done("s2", 1'b0);
    fill(0);
    rmem[0] = PW'(5);
    start_frame(1'b1);
    wait_done("s3", 1'b0);

    // Stall at the first result.
    fill(1);
    rdy = 1'b0;
    start_frame(1'b0);
    cyc = 0;
    while (!vld && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("s4_valid_seen", int'(vld), 1);
    ref_anchor(0, 0, 1'b0, ed, ec);
    repeat (10) begin
      @(negedge clk);
      check("s4_hold_valid", int'(vld), 1);
      check("s4_hold_disp", int'(disp), ed);
      check("s4_hold_cost", int'(cost), ec);
      check("s4_hold_x", int'(xo), 0);
      check("s4_hold_y", int'(yo), 0);
      check("s4_hold_laddr", int'(laddr), (B - 1) * W + (B - 1));
      check("s4_hold_raddr", int'(raddr), (B - 1) * W + (B - 1));
    end
    @(posedge clk); #1;
    rdy = 1'b1;
    @(negedge clk);
    check("s4_xfer_valid", int'(vld), 1);
    @(posedge clk); #1;
    check("s4_xfer_count", n_res, 1);
    check("s4_valid_drop", int'(vld), 0);
    wait_done("s4", 1'b0);

    // Spurious start mid-frame with the other mode.
    fill(2);
    start_frame(1'b0);
    cyc = 0;
    while (n_res < 5 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b1;
    mode  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'b0;
    check("s5_busy_kept", int'(busy), 1);
    wait_done("s5", 1'b1);

    // Asynchronous reset in the middle of a fetch, then a clean restart.
    fill(2);
    start_frame(1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("s6_busy", int'(busy), 0);
    check("s6_valid", int'(vld), 0);
    check("s6_laddr", int'(laddr), 0);
    check("s6_raddr", int'(raddr), 0);
    check("s6_done", int'(fdone), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    start_frame(1'b1);
    wait_done("s6", 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill(2);
      md = 1'($urandom_range(0, 1));
      start_frame(md);
      wait_done("rnd", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
